// File: rtl/coeff_unpack_reader_if.sv
// rtl/coeff_unpack_reader_if.sv - FIFO read port and packed-word output bundle
// Signals:
//   fifo_empty  FIFO empty flag                      (FIFO -> reader)
//   fifo_rd_en  FIFO read enable                     (reader -> FIFO)
//   fifo_data   FIFO read data, 1 cycle after rd_en  (FIFO -> reader)
//   fifo_valid  keep flag returned with fifo_data    (FIFO -> reader)
//   pack_data   LANES packed coefficients, lane 0 oldest (reader -> store)
//   pack_mask   per-lane occupied flags              (reader -> store)
//   pack_valid  pack_data/pack_mask valid            (reader -> store)
//   pack_ready  store accepts the word               (store -> reader)
// Modports: master = reader side, slave = FIFO/store side.
interface coeff_unpack_reader_if #(
  parameter int DATA_WIDTH = 12,
  parameter int LANES      = 6
);
  logic                        fifo_empty;
  logic                        fifo_rd_en;
  logic [DATA_WIDTH-1:0]       fifo_data;
  logic                        fifo_valid;
  logic [LANES*DATA_WIDTH-1:0] pack_data;
  logic [LANES-1:0]            pack_mask;
  logic                        pack_valid;
  logic                        pack_ready;

  modport master (
    input  fifo_empty, fifo_data, fifo_valid, pack_ready,
    output fifo_rd_en, pack_data, pack_mask, pack_valid
  );

  modport slave (
    output fifo_empty, fifo_data, fifo_valid, pack_ready,
    input  fifo_rd_en, pack_data, pack_mask, pack_valid
  );
endinterface

// File: rtl/coeff_unpack_reader.sv
// rtl/coeff_unpack_reader.sv - coefficient FIFO reader that packs accepted samples into LANES-wide words
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   start  1-cycle pulse, begins one polynomial (honoured in IDLE only)
//   busy   high in every state except IDLE
//   done   1-cycle pulse after the last word has transferred
//   bus    coeff_unpack_reader_if.master: FIFO read port and packed-word output
module coeff_unpack_reader #(
  parameter int DATA_WIDTH = 12,
  parameter int LANES      = 6,
  parameter int NUM_COEFFS = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  coeff_unpack_reader_if.master bus
);
  localparam int WORD_W = LANES * DATA_WIDTH;
  localparam int CNT_W  = $clog2(NUM_COEFFS + 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_EMIT    = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  // Counter comparisons are done one bit wider so "+1" never wraps.
  localparam logic [3:0]       LANES_L  = 4'(LANES);
  localparam logic [CNT_W:0]   NUM_L    = (CNT_W + 1)'(NUM_COEFFS);
  localparam logic [CNT_W-1:0] NUM_CNT  = CNT_W'(NUM_COEFFS);

  logic [1:0]        state;
  logic [CNT_W-1:0]  coeff_cnt;
  logic [2:0]        lane_cnt;
  logic              inflight;
  logic [WORD_W-1:0] coll_data;
  logic [LANES-1:0]  coll_mask;
  logic [WORD_W-1:0] coll_data_nxt;
  logic [LANES-1:0]  coll_mask_nxt;

  logic [3:0]        lane_pend;
  logic [CNT_W:0]    coeff_pend;
  logic [3:0]        lane_inc;
  logic [CNT_W:0]    coeff_inc;
  logic              accept;
  logic              word_full;
  logic              quota_met;
  logic              xfer;

  // Count the read already in flight as if it were accepted, so a return
  // can never overflow the lane register or the coefficient quota.
  assign lane_pend  = {1'b0, lane_cnt} + {3'b000, inflight};
  assign coeff_pend = {1'b0, coeff_cnt} + {{CNT_W{1'b0}}, inflight};

  assign bus.fifo_rd_en = (state == S_COLLECT) && !bus.fifo_empty &&
                          (lane_pend < LANES_L) && (coeff_pend < NUM_L);

  assign accept    = (state == S_COLLECT) && inflight && bus.fifo_valid;
  assign lane_inc  = {1'b0, lane_cnt} + 4'd1;
  assign coeff_inc = {1'b0, coeff_cnt} + {{CNT_W{1'b0}}, 1'b1};
  assign word_full = (lane_inc == LANES_L);
  assign quota_met = (coeff_inc == NUM_L);
  assign xfer      = (state == S_EMIT) && bus.pack_valid && bus.pack_ready;

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  // Collection register with the current return merged into lane lane_cnt.
  always_comb begin
    coll_data_nxt = coll_data;
    coll_mask_nxt = coll_mask;
    for (int l = 0; l < LANES; l++) begin
      if (lane_cnt == 3'(l)) begin
        coll_data_nxt[l*DATA_WIDTH +: DATA_WIDTH] = bus.fifo_data;
        coll_mask_nxt[l] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      coeff_cnt      <= '0;
      lane_cnt       <= '0;
      inflight       <= 1'b0;
      coll_data      <= '0;
      coll_mask      <= '0;
      bus.pack_data  <= '0;
      bus.pack_mask  <= '0;
      bus.pack_valid <= 1'b0;
    end else begin
      inflight <= bus.fifo_rd_en;
      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_COLLECT;
            coeff_cnt <= '0;
            lane_cnt  <= '0;
            coll_data <= '0;
            coll_mask <= '0;
          end
        end
        S_COLLECT: begin
          // Rejected returns (fifo_valid low) fall through untouched.
          if (accept) begin
            coll_data <= coll_data_nxt;
            coll_mask <= coll_mask_nxt;
            lane_cnt  <= lane_inc[2:0];
            coeff_cnt <= coeff_inc[CNT_W-1:0];
            // Gating guarantees nothing is outstanding when the word closes.
            if (word_full || quota_met) begin
              bus.pack_data  <= coll_data_nxt;
              bus.pack_mask  <= coll_mask_nxt;
              bus.pack_valid <= 1'b1;
              state          <= S_EMIT;
            end
          end
        end
        S_EMIT: begin
          if (xfer) begin
            bus.pack_valid <= 1'b0;
            if (coeff_cnt == NUM_CNT) begin
              state <= S_DONE;
            end else begin
              lane_cnt  <= '0;
              coll_data <= '0;
              coll_mask <= '0;
              state     <= S_COLLECT;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_coeff_unpack_reader.sv
// tb/tb_coeff_unpack_reader.sv - directed vector bench for coeff_unpack_reader
module tb_coeff_unpack_reader;
  localparam int DW = 12;
  localparam int LN = 6;
  localparam int NC = 256;
  localparam int NW = 43;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic busy;
  logic done;

  coeff_unpack_reader_if #(.DATA_WIDTH(DW), .LANES(LN)) bus();

  coeff_unpack_reader #(.DATA_WIDTH(DW), .LANES(LN), .NUM_COEFFS(NC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .busy  (busy),
    .done  (done),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // FIFO model: {valid, data}; popped entry is presented the following cycle.
  logic [12:0] fq[$];
  logic [12:0] pend = '0;
  logic        pend_v = 1'b0;
  int          cyc = 0;
  int          rd_cnt = 0;
  int          rd_empty_err = 0;
  int          overlap_err = 0;
  int          xfer_cnt = 0;
  int          rd_at_xfer0 = -1;
  int          done_cnt = 0;
  int          done_cyc = -1;
  int          last_xfer_cyc = -1;
  logic [77:0] outq[$];
  int          ready_mode = 0;
  bit          toggle_empty = 1'b0;

  logic [12:0] ent[$];
  logic [11:0] acc_vals[$];
  int          n_main = 0;

  typedef struct {
    logic [11:0][12:0] ent;
    int                n;
    logic [71:0]       exp_data;
    logic [5:0]        exp_mask;
    int                exp_reads;
  } vec_t;

  vec_t vt[5];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timeout waiting for DUT", name);
  endtask

  // FIFO / sink driver and monitor, acting just after each falling edge.
  initial begin
    bus.fifo_empty = 1'b1;
    bus.fifo_data  = '0;
    bus.fifo_valid = 1'b0;
    bus.pack_ready = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      bus.fifo_data  = pend[11:0];
      bus.fifo_valid = pend_v && pend[12];
      pend_v = 1'b0;
      bus.fifo_empty = (fq.size() == 0) || (toggle_empty && ((cyc / 3) % 2 == 1));
      case (ready_mode)
        0:       bus.pack_ready = 1'b1;
        1:       bus.pack_ready = 1'($urandom_range(0, 1));
        default: bus.pack_ready = 1'b0;
      endcase
      #1;
      if (bus.fifo_rd_en) begin
        rd_cnt++;
        if (bus.fifo_empty) rd_empty_err++;
        if (bus.pack_valid) overlap_err++;
        if (fq.size() > 0) begin
          pend   = fq.pop_front();
          pend_v = 1'b1;
        end
      end
      if (bus.pack_valid && bus.pack_ready) begin
        if (xfer_cnt == 0) rd_at_xfer0 = rd_cnt;
        outq.push_back({bus.pack_mask, bus.pack_data});
        xfer_cnt++;
        last_xfer_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic clear_model();
    fq.delete();
    outq.delete();
    pend_v        = 1'b0;
    rd_cnt        = 0;
    rd_empty_err  = 0;
    overlap_err   = 0;
    xfer_cnt      = 0;
    rd_at_xfer0   = -1;
    done_cnt      = 0;
    done_cyc      = -1;
    last_xfer_cyc = -1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #3;
    rst_n = 1'b0;
    clear_model();
    @(negedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    #2 start = 1'b1;
    @(negedge clk);
    #2 start = 1'b0;
  endtask

  task automatic wait_xfer(input int n, input int budget, input string name);
    int k;
    k = 0;
    while (xfer_cnt < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    #2;
    if (xfer_cnt < n) timeout_fail(name);
  endtask

  task automatic run_full(input bit tog, input string tag);
    logic [77:0] expw[NW];
    int          k;
    int          idx;
    do_reset();
    ready_mode   = 1;
    toggle_empty = tog;
    foreach (ent[i]) fq.push_back(ent[i]);
    for (int w = 0; w < NW; w++) begin
      expw[w] = '0;
      for (int l = 0; l < LN; l++) begin
        idx = w * LN + l;
        if (idx < NC) begin
          expw[w][l*DW +: DW] = acc_vals[idx];
          expw[w][72 + l]     = 1'b1;
        end
      end
    end
    pulse_start();
    k = 0;
    while (done_cnt == 0 && k < 20000) begin
      @(negedge clk);
      k++;
    end
    if (done_cnt == 0) timeout_fail({tag, "_done"});
    repeat (5) @(negedge clk);
    #2;
    check({tag, "_words"}, outq.size(), NW);
    for (int w = 0; w < NW && w < outq.size(); w++)
      check($sformatf("%s_word%0d", tag, w), outq[w], expw[w]);
    check({tag, "_done_cnt"}, done_cnt, 1);
    check({tag, "_done_lat"}, done_cyc, last_xfer_cyc + 1);
    check({tag, "_reads"}, rd_cnt, n_main);
    check({tag, "_left"}, fq.size(), 3);
    check({tag, "_rd_empty"}, rd_empty_err, 0);
    check({tag, "_rd_in_emit"}, overlap_err, 0);
    check({tag, "_busy_end"}, busy, 1'b0);
    toggle_empty = 1'b0;
  endtask

  initial begin
    logic [71:0] snap_d;
    logic [5:0]  snap_m;
    bit          stable;
    int          k;
    logic [11:0] v;

    // Vector table: FIFO contents and the first word they must produce.
    for (int i = 0; i < 5; i++) begin
      vt[i].ent      = '0;
      vt[i].exp_mask = 6'h3F;
    end
    for (int i = 0; i < 6; i++) vt[0].ent[i] = {1'b1, 12'(i + 1)};
    vt[0].n = 6;  vt[0].exp_data = 72'h006005004003002001; vt[0].exp_reads = 6;
    for (int i = 0; i < 11; i++)
      vt[1].ent[i] = (i % 2 == 0) ? {1'b1, 12'(12'h0A1 + i / 2)} : {1'b0, 12'hFFF};
    vt[1].n = 11; vt[1].exp_data = 72'h0A60A50A40A30A20A1; vt[1].exp_reads = 11;
    vt[2].ent[0] = {1'b0, 12'hFFF}; vt[2].ent[1] = {1'b0, 12'h5A5};
    vt[2].ent[2] = {1'b1, 12'h123}; vt[2].ent[3] = {1'b1, 12'h456};
    vt[2].ent[4] = {1'b1, 12'h789}; vt[2].ent[5] = {1'b1, 12'hABC};
    vt[2].ent[6] = {1'b1, 12'hDEF}; vt[2].ent[7] = {1'b1, 12'hFED};
    vt[2].n = 8;  vt[2].exp_data = 72'hFEDDEFABC789456123; vt[2].exp_reads = 8;
    for (int i = 0; i < 7; i++) vt[3].ent[i] = {1'b1, 12'(12'h111 * (i + 1))};
    vt[3].n = 7;  vt[3].exp_data = 72'h666555444333222111; vt[3].exp_reads = 6;
    for (int i = 0; i < 5; i++) vt[4].ent[i] = {1'b1, 12'(12'h800 + i)};
    vt[4].ent[5] = {1'b0, 12'hFFF}; vt[4].ent[6] = {1'b0, 12'h000};
    vt[4].ent[7] = {1'b1, 12'h805};
    vt[4].n = 8;  vt[4].exp_data = 72'h805804803802801800; vt[4].exp_reads = 8;

    // Reset state.
    repeat (2) @(negedge clk);
    #2;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_rd_en", bus.fifo_rd_en, 1'b0);
    check("rst_outputs", {bus.pack_valid, bus.pack_mask, bus.pack_data}, '0);
    rst_n = 1'b1;

    for (int t = 0; t < 5; t++) begin
      do_reset();
      ready_mode = 0;
      for (int i = 0; i < vt[t].n; i++) fq.push_back(vt[t].ent[i]);
      pulse_start();
      wait_xfer(1, 100, $sformatf("vec%0d_xfer", t));
      if (outq.size() > 0) begin
        check($sformatf("vec%0d_data", t), outq[0][71:0], vt[t].exp_data);
        check($sformatf("vec%0d_mask", t), outq[0][77:72], vt[t].exp_mask);
      end
      check($sformatf("vec%0d_reads", t), rd_at_xfer0, vt[t].exp_reads);
    end

    // Backpressure: hold ready low for 10 cycles in EMIT; start pulse ignored.
    do_reset();
    ready_mode = 2;
    for (int i = 0; i < 6; i++) fq.push_back({1'b1, 12'(12'h101 + i)});
    pulse_start();
    k = 0;
    while (!bus.pack_valid && k < 50) begin
      @(negedge clk);
      #2;
      k++;
    end
    if (!bus.pack_valid) timeout_fail("hold_enter_emit");
    snap_d = bus.pack_data;
    snap_m = bus.pack_mask;
    stable = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      #2;
      if (c == 3) start = 1'b1;
      if (c == 4) start = 1'b0;
      if (bus.pack_valid !== 1'b1 || bus.pack_data !== snap_d ||
          bus.pack_mask !== snap_m || bus.fifo_rd_en !== 1'b0) stable = 1'b0;
    end
    check("hold_stable", stable, 1'b1);
    check("hold_no_xfer", xfer_cnt, 0);
    check("hold_data", snap_d, 72'h106105104103102101);
    ready_mode = 0;
    @(negedge clk);
    #2;
    check("hold_release_xfer", xfer_cnt, 1);
    @(negedge clk);
    #2;
    check("hold_valid_drop", bus.pack_valid, 1'b0);
    check("hold_still_busy", busy, 1'b1);

    // Full polynomial: 256 accepts, ~30% rejects, 3 extra entries never read.
    ent.delete();
    acc_vals.delete();
    for (int c = 0; c < NC; c++) begin
      while ($urandom_range(0, 99) < 30) ent.push_back({1'b0, 12'($urandom_range(0, 4095))});
      v = 12'($urandom_range(0, 4095));
      ent.push_back({1'b1, v});
      acc_vals.push_back(v);
    end
    n_main = ent.size();
    for (int i = 0; i < 3; i++) ent.push_back({1'b1, 12'($urandom_range(0, 4095))});
    run_full(1'b0, "full");
    run_full(1'b1, "toggle");

    // Asynchronous reset mid-COLLECT, then restart from lane 0.
    do_reset();
    ready_mode = 0;
    for (int i = 0; i < 9; i++) fq.push_back({1'b1, 12'(12'h201 + i)});
    pulse_start();
    wait_xfer(1, 100, "arst_first_word");
    @(negedge clk);
    @(negedge clk);
    #3;
    check("arst_pre_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("arst_outputs", {bus.pack_valid, bus.pack_mask, bus.pack_data}, '0);
    check("arst_busy", busy, 1'b0);
    check("arst_done", done, 1'b0);
    check("arst_rd_en", bus.fifo_rd_en, 1'b0);
    @(negedge clk);
    #3;
    clear_model();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) fq.push_back({1'b1, 12'(12'h301 + i)});
    pulse_start();
    wait_xfer(1, 100, "arst_restart");
    if (outq.size() > 0)
      check("arst_restart_word", outq[0], {6'h3F, 72'h306305304303302301});
    check("arst_restart_reads", rd_at_xfer0, 6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
